// File: rtl/udma_tx_prefetch_buf.sv
// udma_tx_prefetch_buf
// TX prefetch buffer between one linear uDMA TX channel port and a peripheral
// serialiser. Reads are requested upstream only while a FIFO slot is reserved
// for every outstanding read, so the response path never has to stall. Each
// buffered word carries the datasize that was in force when it was granted.
module udma_tx_prefetch_buf #(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned DEPTH      = 4,
  localparam int unsigned CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_en_i,
  input  logic [1:0]            cfg_datasize_i,
  input  logic                  flush_i,
  output logic                  ch_req_o,
  output logic [1:0]            ch_datasize_o,
  input  logic                  ch_gnt_i,
  input  logic                  ch_valid_i,
  input  logic [DATA_WIDTH-1:0] ch_data_i,
  output logic                  ch_ready_o,
  output logic                  per_valid_o,
  output logic [DATA_WIDTH-1:0] per_data_o,
  output logic [1:0]            per_datasize_o,
  input  logic                  per_ready_i,
  output logic [CW-1:0]         elements_o,
  output logic                  busy_o
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  // Data FIFO storage (word plus its size tag)
  logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
  logic [1:0]            r_dsz_mem  [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  // Size tag FIFO: one entry per outstanding read, in grant order
  logic [1:0]            r_tag_mem  [DEPTH];
  logic [AW-1:0]         r_tag_wptr;
  logic [AW-1:0]         r_tag_rptr;

  // Outstanding reads and stale responses still to be discarded
  logic [CW-1:0]         r_in_flight;
  logic [CW-1:0]         r_discard;

  logic                  w_full;
  logic [CW-1:0]         w_credit_used;
  logic                  w_req;
  logic                  w_gnt;
  logic                  w_rsp;
  logic                  w_drop;
  logic                  w_push;
  logic                  w_pop;
  logic [1:0]            w_rsp_tag;

  // Handshake decode; the request depends only on registered state and levels
  always_comb begin
    w_credit_used = r_count + r_in_flight;
    w_full        = (r_count == LP_DEPTH);
    w_req         = ~rst_i & cfg_en_i & ~flush_i & (w_credit_used < LP_DEPTH);
    w_gnt         = w_req & ch_gnt_i;
    w_rsp         = ch_valid_i & ~w_full;
    // a response landing in the flush cycle is stale as well
    w_drop        = w_rsp & (flush_i | (r_discard != '0));
    w_push        = w_rsp & ~w_drop;
    w_pop         = (r_count != '0) & per_ready_i & ~flush_i;
    w_rsp_tag     = r_tag_mem[r_tag_rptr];
  end

  // Size tag FIFO: push on grant, pop on every accepted response (kept or dropped)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tag_wptr <= '0;
      r_tag_rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_tag_mem[i] <= '0;
      end
    end else begin
      if (w_gnt) begin
        r_tag_mem[r_tag_wptr] <= cfg_datasize_i;
        r_tag_wptr            <= r_tag_wptr + 1'b1;
      end
      if (w_rsp) begin
        r_tag_rptr <= r_tag_rptr + 1'b1;
      end
    end
  end

  // Data FIFO: registered storage, no fall-through; flush empties it at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_data_mem[i] <= '0;
        r_dsz_mem[i]  <= '0;
      end
    end else if (flush_i) begin
      // no push can happen in a flush cycle, so read pointer simply catches up
      r_rptr  <= r_wptr;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_data_mem[r_wptr] <= ch_data_i;
        r_dsz_mem[r_wptr]  <= w_rsp_tag;
        r_wptr             <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Outstanding-read and discard accounting
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_in_flight <= '0;
      r_discard   <= '0;
    end else begin
      r_in_flight <= r_in_flight + CW'(w_gnt) - CW'(w_rsp);
      if (flush_i) begin
        // everything still outstanding after this cycle is stale
        r_discard <= r_in_flight - CW'(w_rsp);
      end else if (w_rsp && (r_discard != '0)) begin
        r_discard <= r_discard - 1'b1;
      end
    end
  end

  // Output drive
  always_comb begin
    ch_req_o       = w_req;
    ch_datasize_o  = cfg_datasize_i;
    ch_ready_o     = ~w_full;
    per_valid_o    = (r_count != '0);
    per_data_o     = r_data_mem[r_rptr];
    per_datasize_o = r_dsz_mem[r_rptr];
    elements_o     = r_count;
    busy_o         = (r_in_flight != '0) | (r_count != '0);
  end

  // Upstream must never present data that has no reserved slot
  a_no_credit_violation: assert property (@(posedge clk_i) disable iff (rst_i)
    !(ch_valid_i && w_full));

  // A response must always correspond to an outstanding grant
  a_no_orphan_response: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_rsp && (r_in_flight == '0)));

  // Outstanding reads plus buffered words never exceed the FIFO size
  a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    (({1'b0, r_count} + {1'b0, r_in_flight}) <= (CW + 1)'(DEPTH)));

endmodule

// File: tb/tb_udma_tx_prefetch_buf.sv
// Bench for udma_tx_prefetch_buf: directed scenarios plus a randomized run,
// all checked cycle by cycle against a queue-based reference model and an
// in-order upstream responder with configurable read latency.
module tb_udma_tx_prefetch_buf;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          cfg_en_i;
  logic [1:0]    cfg_datasize_i;
  logic          flush_i;
  logic          ch_req_o;
  logic [1:0]    ch_datasize_o;
  logic          ch_gnt_i;
  logic          ch_valid_i;
  logic [DW-1:0] ch_data_i;
  logic          ch_ready_o;
  logic          per_valid_o;
  logic [DW-1:0] per_data_o;
  logic [1:0]    per_datasize_o;
  logic          per_ready_i;
  logic [CW-1:0] elements_o;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  udma_tx_prefetch_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cfg_en_i       (cfg_en_i),
    .cfg_datasize_i (cfg_datasize_i),
    .flush_i        (flush_i),
    .ch_req_o       (ch_req_o),
    .ch_datasize_o  (ch_datasize_o),
    .ch_gnt_i       (ch_gnt_i),
    .ch_valid_i     (ch_valid_i),
    .ch_data_i      (ch_data_i),
    .ch_ready_o     (ch_ready_o),
    .per_valid_o    (per_valid_o),
    .per_data_o     (per_data_o),
    .per_datasize_o (per_datasize_o),
    .per_ready_i    (per_ready_i),
    .elements_o     (elements_o),
    .busy_o         (busy_o)
  );

  typedef struct packed {
    logic [1:0]    size;
    logic [DW-1:0] data;
  } word_t;

  int checks = 0;
  int errors = 0;

  // reference model: words the peripheral should see, in order
  word_t      m_q[$];
  logic [1:0] m_tags[$];
  int         m_inflight;
  int         m_discard;

  // upstream responder
  logic [DW-1:0] up_data[$];
  int            up_due[$];
  logic [DW-1:0] up_src[$];
  int            up_lat;
  bit            up_lat_rand;

  // statistics
  int    cyc = 0;
  int    n_gnt, n_pop, n_req_low, max_elem, last_pop_cyc;
  word_t pop_log[$];

  task automatic clear_state();
    m_q.delete(); m_tags.delete(); m_inflight = 0; m_discard = 0;
    up_data.delete(); up_due.delete(); up_src.delete();
    up_lat = 2; up_lat_rand = 0;
    n_gnt = 0; n_pop = 0; n_req_low = 0; max_elem = 0; last_pop_cyc = -1;
    pop_log.delete();
  endtask

  task automatic apply_reset();
    cfg_en_i = 0; cfg_datasize_i = 0; flush_i = 0; ch_gnt_i = 0;
    ch_valid_i = 0; ch_data_i = '0; per_ready_i = 0;
    rst_i = 0; #1; rst_i = 1;
    clear_state();
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 0;
  endtask

  // One clock: drive upstream, check against model, advance model and upstream.
  // Entered and left at a negative clock edge.
  task automatic cycle();
    logic exp_req, exp_pv, exp_busy, exp_rdy, m_gnt, m_rsp, u_gnt, u_rsp;
    logic [1:0] tag;
    logic [DW-1:0] d;
    word_t w;
    int due;
    ch_valid_i = (up_due.size() > 0) ? (up_due[0] <= cyc) : 1'b0;
    ch_data_i  = ch_valid_i ? up_data[0] : '0;
    #1;
    exp_rdy  = (m_q.size() < DEPTH);
    exp_req  = cfg_en_i && !flush_i && !rst_i && ((m_q.size() + m_inflight) < DEPTH);
    exp_pv   = (m_q.size() > 0);
    exp_busy = (m_inflight != 0) || (m_q.size() != 0);

    checks++; if (ch_req_o !== exp_req) begin errors++;
      $display("FAIL ch_req_o cyc=%0d: got %b expected %b", cyc, ch_req_o, exp_req); end
    checks++; if (ch_datasize_o !== cfg_datasize_i) begin errors++;
      $display("FAIL ch_datasize_o cyc=%0d: got %0d expected %0d", cyc, ch_datasize_o, cfg_datasize_i); end
    checks++; if (ch_ready_o !== exp_rdy) begin errors++;
      $display("FAIL ch_ready_o cyc=%0d: got %b expected %b", cyc, ch_ready_o, exp_rdy); end
    checks++; if (elements_o !== CW'(m_q.size())) begin errors++;
      $display("FAIL elements_o cyc=%0d: got %0d expected %0d", cyc, elements_o, m_q.size()); end
    checks++; if (busy_o !== exp_busy) begin errors++;
      $display("FAIL busy_o cyc=%0d: got %b expected %b", cyc, busy_o, exp_busy); end
    checks++; if (per_valid_o !== exp_pv) begin errors++;
      $display("FAIL per_valid_o cyc=%0d: got %b expected %b", cyc, per_valid_o, exp_pv); end
    if (exp_pv) begin
      w = m_q[0];
      checks++; if (per_data_o !== w.data) begin errors++;
        $display("FAIL per_data_o cyc=%0d: got %h expected %h", cyc, per_data_o, w.data); end
      checks++; if (per_datasize_o !== w.size) begin errors++;
        $display("FAIL per_datasize_o cyc=%0d: got %0d expected %0d", cyc, per_datasize_o, w.size); end
    end
    if (ch_valid_i) begin
      checks++; if (ch_ready_o !== 1'b1) begin errors++;
        $display("FAIL credit cyc=%0d: ch_ready_o got %b while ch_valid_i, expected 1", cyc, ch_ready_o); end
    end

    u_gnt = ch_req_o && ch_gnt_i;
    u_rsp = ch_valid_i && ch_ready_o;
    if (u_gnt) n_gnt++;
    if (!ch_req_o) n_req_low++;
    if (int'(elements_o) > max_elem) max_elem = int'(elements_o);
    if (per_valid_o && per_ready_i && !flush_i) begin
      pop_log.push_back({per_datasize_o, per_data_o});
      n_pop++;
      last_pop_cyc = cyc;
    end

    m_gnt = exp_req && ch_gnt_i;
    m_rsp = ch_valid_i && exp_rdy;
    tag = 2'd0;
    if (m_rsp && (m_tags.size() > 0)) tag = m_tags.pop_front();
    if (flush_i) begin
      m_q.delete();
      m_discard = m_inflight - (m_rsp ? 1 : 0);
    end else begin
      if (exp_pv && per_ready_i) void'(m_q.pop_front());
      if (m_rsp) begin
        if (m_discard > 0) m_discard--;
        else m_q.push_back({tag, ch_data_i});
      end
    end
    m_inflight = m_inflight + (m_gnt ? 1 : 0) - (m_rsp ? 1 : 0);
    if (m_gnt) m_tags.push_back(cfg_datasize_i);

    if (u_rsp) begin
      void'(up_data.pop_front());
      void'(up_due.pop_front());
    end
    if (u_gnt) begin
      if (up_src.size() > 0) d = up_src.pop_front();
      else begin
        d = $urandom();
        if (cfg_datasize_i == 2'd0) d = d & 32'h0000_00FF;
        else if (cfg_datasize_i == 2'd1) d = d & 32'h0000_FFFF;
      end
      due = cyc + (up_lat_rand ? int'($urandom_range(1, 4)) : up_lat);
      if ((up_due.size() > 0) && (due < up_due[$])) due = up_due[$];
      up_data.push_back(d);
      up_due.push_back(due);
    end

    @(posedge clk_i); @(negedge clk_i);
    cyc++;
  endtask

  task automatic test_reset();
    rst_i = 0; #1; rst_i = 1;
    cfg_en_i = 1; cfg_datasize_i = 2; flush_i = 0; ch_gnt_i = 1;
    ch_valid_i = 0; ch_data_i = '0; per_ready_i = 1;
    clear_state();
    #2;
    checks++; if (ch_req_o !== 1'b0) begin errors++; $display("FAIL reset ch_req_o: got %b expected 0", ch_req_o); end
    checks++; if (per_valid_o !== 1'b0) begin errors++; $display("FAIL reset per_valid_o: got %b expected 0", per_valid_o); end
    checks++; if (per_data_o !== '0) begin errors++; $display("FAIL reset per_data_o: got %h expected 0", per_data_o); end
    checks++; if (per_datasize_o !== 2'd0) begin errors++; $display("FAIL reset per_datasize_o: got %0d expected 0", per_datasize_o); end
    checks++; if (elements_o !== '0) begin errors++; $display("FAIL reset elements_o: got %0d expected 0", elements_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset busy_o: got %b expected 0", busy_o); end
    checks++; if (ch_ready_o !== 1'b1) begin errors++; $display("FAIL reset ch_ready_o: got %b expected 1", ch_ready_o); end
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 0; cfg_en_i = 0; ch_gnt_i = 0; per_ready_i = 0;
  endtask

  task automatic test_credit();
    apply_reset();
    cfg_en_i = 1; ch_gnt_i = 1; per_ready_i = 0;
    for (int i = 0; i < 12; i++) begin
      cfg_datasize_i = 2'($urandom_range(0, 2));
      cycle();
    end
    checks++; if (n_gnt !== 4) begin errors++; $display("FAIL credit grants: got %0d expected 4", n_gnt); end
    checks++; if (elements_o !== CW'(4)) begin errors++; $display("FAIL credit elements_o: got %0d expected 4", elements_o); end
    #1;
    checks++; if (ch_req_o !== 1'b0) begin errors++; $display("FAIL credit ch_req_o full: got %b expected 0", ch_req_o); end
  endtask

  task automatic test_order();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 32'h0000_00AA; exp_d[1] = 32'h0000_BBBB; exp_d[2] = 32'hCCCC_CCCC;
    apply_reset();
    for (int i = 0; i < 3; i++) up_src.push_back(exp_d[i]);
    cfg_en_i = 1; per_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      ch_gnt_i = 1; cfg_datasize_i = 2'(i);
      cycle();
    end
    ch_gnt_i = 0; cfg_datasize_i = 2'd1;
    for (int i = 0; i < 8; i++) cycle();
    checks++; if (pop_log.size() !== 3) begin errors++; $display("FAIL order count: got %0d expected 3", pop_log.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < pop_log.size()) begin
        checks++; if (pop_log[i].data !== exp_d[i]) begin errors++;
          $display("FAIL order data[%0d]: got %h expected %h", i, pop_log[i].data, exp_d[i]); end
        checks++; if (pop_log[i].size !== 2'(i)) begin errors++;
          $display("FAIL order size[%0d]: got %0d expected %0d", i, pop_log[i].size, i); end
      end
    end
  endtask

  task automatic test_stream();
    apply_reset();
    cfg_en_i = 1; ch_gnt_i = 1; per_ready_i = 1;
    for (int i = 0; i < 40; i++) begin
      cfg_datasize_i = 2'($urandom_range(0, 2));
      cycle();
    end
    checks++; if (n_req_low !== 0) begin errors++; $display("FAIL stream req drops: got %0d expected 0", n_req_low); end
    checks++; if (n_pop !== 37) begin errors++; $display("FAIL stream pops: got %0d expected 37", n_pop); end
    checks++; if (max_elem > 2) begin errors++; $display("FAIL stream max elements: got %0d expected <=2", max_elem); end
  endtask

  task automatic test_reset_midrun();
    apply_reset();
    cfg_en_i = 1; ch_gnt_i = 1; per_ready_i = 0;
    for (int i = 0; i < 5; i++) cycle();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL midrun busy before reset: got %b expected 1", busy_o); end
    #2; rst_i = 1; #1;
    checks++; if (ch_req_o !== 1'b0) begin errors++; $display("FAIL midrun ch_req_o: got %b expected 0", ch_req_o); end
    checks++; if (per_valid_o !== 1'b0) begin errors++; $display("FAIL midrun per_valid_o: got %b expected 0", per_valid_o); end
    checks++; if (elements_o !== '0) begin errors++; $display("FAIL midrun elements_o: got %0d expected 0", elements_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrun busy_o: got %b expected 0", busy_o); end
    clear_state();
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 0;
    for (int i = 0; i < 6; i++) cycle();
  endtask

  task automatic test_flush();
    apply_reset();
    cfg_en_i = 1; ch_gnt_i = 1; per_ready_i = 0;
    for (int i = 0; i < 4; i++) cycle();
    checks++; if (elements_o !== CW'(2)) begin errors++; $display("FAIL flush pre elements_o: got %0d expected 2", elements_o); end
    ch_gnt_i = 0; flush_i = 1;
    cycle();
    flush_i = 0;
    checks++; if (elements_o !== '0) begin errors++; $display("FAIL flush elements_o: got %0d expected 0", elements_o); end
    pop_log.delete();
    up_src.push_back(32'h0000_1234);
    ch_gnt_i = 1; cfg_datasize_i = 2'd2; per_ready_i = 1;
    cycle();
    ch_gnt_i = 0;
    for (int i = 0; i < 6; i++) cycle();
    checks++; if (pop_log.size() !== 1) begin errors++; $display("FAIL flush words after: got %0d expected 1", pop_log.size()); end
    if (pop_log.size() > 0) begin
      checks++; if (pop_log[0].data !== 32'h0000_1234) begin errors++;
        $display("FAIL flush first data: got %h expected 00001234", pop_log[0].data); end
    end
  endtask

  task automatic test_disable();
    apply_reset();
    up_lat = 5;
    cfg_en_i = 1; ch_gnt_i = 1; per_ready_i = 0;
    for (int i = 0; i < 3; i++) cycle();
    cfg_en_i = 0; per_ready_i = 1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (busy_o === 1'b0) break;
    end
    checks++; if (n_gnt !== 3) begin errors++; $display("FAIL disable grants: got %0d expected 3", n_gnt); end
    checks++; if (n_pop !== 3) begin errors++; $display("FAIL disable pops: got %0d expected 3", n_pop); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL disable busy_o timeout: got %b expected 0", busy_o); end
    checks++; if (cyc !== last_pop_cyc + 1) begin errors++;
      $display("FAIL disable busy fall: got cycle %0d expected %0d", cyc, last_pop_cyc + 1); end
  endtask

  task automatic test_random();
    apply_reset();
    up_lat_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      cfg_en_i       = ($urandom_range(0, 9) != 0);
      ch_gnt_i       = ($urandom_range(0, 9) < 7);
      per_ready_i    = ($urandom_range(0, 9) < 6);
      cfg_datasize_i = 2'($urandom_range(0, 2));
      flush_i        = ($urandom_range(0, 19) == 0);
      cycle();
    end
    flush_i = 0;
    checks++; if (n_pop == 0) begin errors++; $display("FAIL random pops: got 0 expected >0"); end
  endtask

  initial begin
    test_reset();
    test_credit();
    test_order();
    test_stream();
    test_reset_midrun();
    test_flush();
    test_disable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
